// File: rtl/ncl_sync_receiver.sv
// Clocked sink for a dual-rail NCL four-phase pipeline: synchronises the rails, detects
// DATA/NULL wavefronts, drives completion and queues words in a 2-entry FIFO.
// Optional NCL_RX_ERR_EN: sticky err on a both-rails-high bit and flush of that wavefront.
//
// state   | meaning
// W_DATA  | din_comp=0, waiting for a complete DATA wavefront and a free FIFO slot
// CONFIRM | one cycle, re-checks the wavefront against the value latched on entry
// W_NULL  | din_comp=1, waiting for all rails to return low
module ncl_sync_receiver #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic [WIDTH-1:0] din_r0,
  input  logic [WIDTH-1:0] din_r1,
  output logic             din_comp,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  typedef enum logic [1:0] {W_DATA, CONFIRM, W_NULL} state_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r0_q, sync_r0_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r1_q, sync_r1_d;
  logic [WIDTH-1:0]                  s_r0, s_r1;

  state_t           state_q, state_d;
  logic             din_comp_q, din_comp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] latch_q, latch_d;

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;

  logic complete, is_null, push, pop;

  assign s_r0 = sync_r0_q[SYNC_STAGES-1];
  assign s_r1 = sync_r1_q[SYNC_STAGES-1];

  // both-rails-high bits fail the XOR, so they never count as complete
  assign complete = &(s_r0 ^ s_r1);
  assign is_null  = ~|{s_r0, s_r1};

  assign pop       = (count_q != 2'd0) && out_ready;
  assign din_comp  = din_comp_q;
  assign err       = err_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    sync_r0_d = {sync_r0_q[SYNC_STAGES-2:0], din_r0};
    sync_r1_d = {sync_r1_q[SYNC_STAGES-2:0], din_r1};
  end

  always_comb begin
    state_d    = state_q;
    din_comp_d = din_comp_q;
    latch_d    = latch_q;
    push       = 1'b0;
    case (state_q)
      W_DATA: begin
        if (complete && count_q != 2'd2) begin
          state_d = CONFIRM;
          latch_d = s_r1;
        end
      end
      CONFIRM: begin
        if (complete && s_r1 == latch_q) begin
          push       = 1'b1;
          din_comp_d = 1'b1;
          state_d    = W_NULL;
        end else begin
          state_d = W_DATA;
        end
      end
      W_NULL: begin
        if (is_null) begin
          din_comp_d = 1'b0;
          state_d    = W_DATA;
        end
      end
      default: state_d = W_DATA;
    endcase
`ifdef NCL_RX_ERR_EN
    err_d = err_q | (|(s_r0 & s_r1));
    if (|(s_r0 & s_r1)) begin
      push       = 1'b0;
      din_comp_d = 1'b1;
      state_d    = W_NULL;
    end
`else
    err_d = 1'b0;
`endif
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_r1;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      sync_r0_q  <= '0;
      sync_r1_q  <= '0;
      state_q    <= W_DATA;
      din_comp_q <= 1'b0;
      err_q      <= 1'b0;
      latch_q    <= '0;
      mem_q      <= '0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      sync_r0_q  <= sync_r0_d;
      sync_r1_q  <= sync_r1_d;
      state_q    <= state_d;
      din_comp_q <= din_comp_d;
      err_q      <= err_d;
      latch_q    <= latch_d;
      mem_q      <= mem_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_ncl_sync_receiver.sv
// Scoreboard bench for ncl_sync_receiver (WIDTH=4, SYNC_STAGES=2); define NCL_RX_ERR_EN
// on both files to exercise the error path.
module tb_ncl_sync_receiver;

  logic       clk = 1'b0;
  logic       init_n;
  logic [3:0] din_r0, din_r1;
  logic       din_comp;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       err;

  int tests = 0;
  int fails = 0;
  int pop_cnt = 0;
  logic [3:0] exp_q[$];

  ncl_sync_receiver #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .init_n(init_n), .din_r0(din_r0), .din_r1(din_r1),
    .din_comp(din_comp), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  // pops happen on the next posedge; compare the word being popped here
  always @(negedge clk) begin
    if (init_n && out_valid && out_ready) begin
      logic [3:0] e;
      tests++;
      pop_cnt++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got %h, expected no word", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          fails++;
          $display("FAIL pop_data: got %h, expected %h", out_data, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [3:0] w);
    din_r1 = w;
    din_r0 = ~w;
  endtask

  task automatic drive_null();
    din_r1 = '0;
    din_r0 = '0;
  endtask

  task automatic wait_comp(input logic level, input int budget, input string name);
    int i = 0;
    while (din_comp !== level && i < budget) begin
      tick(1);
      i++;
    end
    tests++;
    if (din_comp !== level) begin
      fails++;
      $display("FAIL %s: din_comp=%b, expected %b within %0d cycles", name, din_comp, level, budget);
    end
  endtask

  task automatic test_reset();
    init_n = 1'b0; out_ready = 1'b1; drive_null();
    tick(3);
    tests++;
    if ({din_comp, out_valid, out_data, err} !== 7'b0) begin
      fails++;
      $display("FAIL reset: comp=%b valid=%b data=%h err=%b, expected all 0",
               din_comp, out_valid, out_data, err);
    end
    init_n = 1'b1;
    tick(2);
  endtask

  task automatic test_latency();
    drive_word(4'hA);
    exp_q.push_back(4'hA);
    tick(3);
    tests++;
    if (din_comp !== 1'b0) begin
      fails++; $display("FAIL lat_early: din_comp=%b, expected 0 at cycle 3", din_comp);
    end
    tick(1);
    tests++;
    if ({din_comp, out_valid, out_data} !== {1'b1, 1'b1, 4'hA}) begin
      fails++;
      $display("FAIL lat_data: comp=%b valid=%b data=%h, expected 1 1 a", din_comp, out_valid, out_data);
    end
    drive_null();
    tick(2);
    tests++;
    if (din_comp !== 1'b1) begin
      fails++; $display("FAIL null_early: din_comp=%b, expected 1 at cycle 2", din_comp);
    end
    tick(1);
    tests++;
    if (din_comp !== 1'b0) begin
      fails++; $display("FAIL null_lat: din_comp=%b, expected 0 at cycle 3", din_comp);
    end
  endtask

  task automatic test_skew();
    logic [3:0] tgt = 4'h5;
    for (int i = 0; i < 4; i++) begin
      din_r1[i] = tgt[i];
      din_r0[i] = ~tgt[i];
      tick(1);
      tests++;
      if (din_comp !== 1'b0) begin
        fails++; $display("FAIL skew_partial: din_comp=%b at bit %0d, expected 0", din_comp, i);
      end
    end
    exp_q.push_back(tgt);
    wait_comp(1'b1, 20, "skew_comp");
    drive_null();
    wait_comp(1'b0, 20, "skew_null");
    tick(2);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int w = 1; w <= 2; w++) begin
      drive_word(4'(w));
      exp_q.push_back(4'(w));
      wait_comp(1'b1, 20, "bp_comp");
      drive_null();
      wait_comp(1'b0, 20, "bp_null");
    end
    drive_word(4'h3);
    exp_q.push_back(4'h3);
    tick(10);
    tests++;
    if ({din_comp, out_valid, out_data} !== {1'b0, 1'b1, 4'h1}) begin
      fails++;
      $display("FAIL bp_hold: comp=%b valid=%b data=%h, expected 0 1 1", din_comp, out_valid, out_data);
    end
    out_ready = 1'b1;
    wait_comp(1'b1, 30, "bp_release");
    drive_null();
    wait_comp(1'b0, 20, "bp_release_null");
    tick(3);
    tests++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: pending=%0d valid=%b, expected 0 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int start = pop_cnt;
    logic [3:0] words[2] = '{4'hF, 4'h0};
    out_ready = 1'b1;
    foreach (words[k]) begin
      drive_word(words[k]);
      exp_q.push_back(words[k]);
      wait_comp(1'b1, 20, "b2b_comp");
      drive_null();
      wait_comp(1'b0, 20, "b2b_null");
    end
    tick(5);
    tests++;
    if (pop_cnt - start != 2 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_count: pops=%0d pending=%0d, expected 2 0", pop_cnt - start, exp_q.size());
    end
  endtask

  task automatic test_illegal();
    int start = pop_cnt;
    din_r1 = 4'b0100;
    din_r0 = 4'b1111;
`ifdef NCL_RX_ERR_EN
    wait_comp(1'b1, 20, "err_flush");
    tests++;
    if (err !== 1'b1 || out_valid !== 1'b0 || pop_cnt != start) begin
      fails++;
      $display("FAIL err_set: err=%b valid=%b pops=%0d, expected 1 0 0", err, out_valid, pop_cnt - start);
    end
    drive_null();
    wait_comp(1'b0, 20, "err_null");
    drive_word(4'h6);
    exp_q.push_back(4'h6);
    wait_comp(1'b1, 20, "err_recover");
    drive_null();
    wait_comp(1'b0, 20, "err_recover_null");
    tick(3);
    tests++;
    if (err !== 1'b1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL err_sticky: err=%b pending=%0d, expected 1 0", err, exp_q.size());
    end
`else
    tick(10);
    tests++;
    if (din_comp !== 1'b0 || err !== 1'b0 || pop_cnt != start) begin
      fails++;
      $display("FAIL illegal_wait: comp=%b err=%b pops=%0d, expected 0 0 0", din_comp, err, pop_cnt - start);
    end
    drive_null();
    tick(5);
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_word(4'h9);
    wait_comp(1'b1, 20, "rst_mid_comp");
    tick(1);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL rst_mid_fill: valid=%b, expected 1", out_valid);
    end
    init_n = 1'b0;
    drive_null();
    tick(1);
    tests++;
    if ({din_comp, out_valid, err, out_data} !== 7'b0) begin
      fails++;
      $display("FAIL rst_mid: comp=%b valid=%b err=%b data=%h, expected all 0",
               din_comp, out_valid, err, out_data);
    end
    init_n = 1'b1;
    out_ready = 1'b1;
    tick(5);
    tests++;
    if (out_valid !== 1'b0 || din_comp !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL rst_mid_after: valid=%b comp=%b pending=%0d, expected 0 0 0",
               out_valid, din_comp, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_skew();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
